// File: rtl/sobel_rd_fetch_if.sv
// Bus bundle for the sobel read-fetch engine: CCI-P c0 request/response and the t_block stream.
// master = fetch engine side, slave = shim/consumer side.
interface sobel_rd_fetch_if #(
  parameter int unsigned ADDR_W = 42,
  parameter int unsigned TAG_W  = 4
);
  localparam int unsigned BLK_W = 512;

  logic              rd_req_valid;
  logic [ADDR_W-1:0] rd_req_addr;
  logic [TAG_W-1:0]  rd_req_tag;
  logic              rd_req_almfull;
  logic              rd_rsp_valid;
  logic [TAG_W-1:0]  rd_rsp_tag;
  logic [BLK_W-1:0]  rd_rsp_data;
  logic              blk_valid;
  logic [BLK_W-1:0]  blk_data;
  logic              blk_last;
  logic              blk_ready;

  modport master (
    output rd_req_valid, rd_req_addr, rd_req_tag,
    input  rd_req_almfull,
    input  rd_rsp_valid, rd_rsp_tag, rd_rsp_data,
    output blk_valid, blk_data, blk_last,
    input  blk_ready
  );

  modport slave (
    input  rd_req_valid, rd_req_addr, rd_req_tag,
    output rd_req_almfull,
    output rd_rsp_valid, rd_rsp_tag, rd_rsp_data,
    input  blk_valid, blk_data, blk_last,
    output blk_ready
  );
endinterface

// File: rtl/sobel_rd_fetch.sv
// Read-side fetch engine: issues c0 line reads, reorders responses by tag in a ROB,
// and streams blocks to the compute pipeline in address order.
module sobel_rd_fetch #(
  parameter int unsigned MAX_OUTSTANDING = 16,
  parameter int unsigned TAG_W           = $clog2(MAX_OUTSTANDING),
  parameter int unsigned ADDR_W          = 42,
  parameter int unsigned SIZE_W          = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [SIZE_W-1:0] num_lines,
  output logic              busy,
  output logic              done,
  output logic              err,
  sobel_rd_fetch_if.master  bus
);
  localparam int unsigned CNT_W = SIZE_W + 1;
  localparam int unsigned BLK_W = 512;

  localparam logic [1:0] S_RD_IDLE   = 2'd0;
  localparam logic [1:0] S_RD_FETCH  = 2'd1;
  localparam logic [1:0] S_RD_FINISH = 2'd2;

  logic [1:0]                 state, state_next;
  logic                       busy_next, done_next;
  logic [ADDR_W-1:0]          base_q;
  logic [CNT_W-1:0]           lines_q, issued, emitted, in_flight;
  logic [MAX_OUTSTANDING-1:0] rob_vld, rob_vld_next;
  logic [BLK_W-1:0]           rob_data [MAX_OUTSTANDING];
  logic [TAG_W-1:0]           head, rsp_off;
  logic                       issue, pop, final_pop, blk_vld;
  logic                       rsp_live, rsp_pending, rsp_accept;
  logic                       req_valid_q;
  logic [ADDR_W-1:0]          req_addr_q;
  logic [TAG_W-1:0]           req_tag_q;

  assign head      = emitted[TAG_W-1:0];
  assign in_flight = issued - emitted;

  // A tag is pending when it lies inside the window [emitted, issued) modulo the ROB depth.
  assign rsp_off     = bus.rd_rsp_tag - head;
  assign rsp_pending = CNT_W'(rsp_off) < in_flight;
  assign rsp_live    = bus.rd_rsp_valid && (state != S_RD_IDLE);
  assign rsp_accept  = rsp_live && rsp_pending && !rob_vld[bus.rd_rsp_tag];

  assign issue = (state == S_RD_FETCH) && (issued < lines_q) && !bus.rd_req_almfull
              && (in_flight < CNT_W'(MAX_OUTSTANDING));

  assign blk_vld   = (state == S_RD_FETCH) && rob_vld[head];
  assign pop       = blk_vld && bus.blk_ready;
  assign final_pop = pop && ((emitted + CNT_W'(1)) == lines_q);

  assign bus.blk_valid    = blk_vld;
  assign bus.blk_data     = rob_data[head];
  assign bus.blk_last     = blk_vld && (emitted == (lines_q - CNT_W'(1)));
  assign bus.rd_req_valid = req_valid_q;
  assign bus.rd_req_addr  = req_addr_q;
  assign bus.rd_req_tag   = req_tag_q;

  // State register with registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_RD_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= busy_next;
      done  <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_RD_IDLE:   if (start) state_next = (num_lines != '0) ? S_RD_FETCH : S_RD_FINISH;
      S_RD_FETCH:  if (final_pop) state_next = S_RD_FINISH;
      S_RD_FINISH: state_next = S_RD_IDLE;
      default:     state_next = S_RD_IDLE;
    endcase
    busy_next = (state_next != S_RD_IDLE);
    done_next = (state_next == S_RD_FINISH);
  end

  // Write and pop always hit different slots, so both apply in one cycle.
  always_comb begin
    rob_vld_next = rob_vld;
    if (rsp_accept) rob_vld_next[bus.rd_rsp_tag] = 1'b1;
    if (pop)        rob_vld_next[head]           = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base_q      <= '0;
      lines_q     <= '0;
      issued      <= '0;
      emitted     <= '0;
      rob_vld     <= '0;
      err         <= 1'b0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      req_tag_q   <= '0;
    end else begin
      if ((state == S_RD_IDLE) && start) begin
        base_q  <= base_addr;
        lines_q <= CNT_W'(num_lines);
        issued  <= '0;
        emitted <= '0;
      end
      req_valid_q <= issue;
      if (issue) begin
        req_addr_q <= base_q + ADDR_W'(issued);
        req_tag_q  <= issued[TAG_W-1:0];
        issued     <= issued + CNT_W'(1);
      end
      if (pop) emitted <= emitted + CNT_W'(1);
      if (rsp_live && !rsp_accept) err <= 1'b1;
      rob_vld <= rob_vld_next;
    end
  end

  // ROB payload storage; validity is tracked separately so no reset is needed.
  always_ff @(posedge clk) begin
    if (rsp_accept) rob_data[bus.rd_rsp_tag] <= bus.rd_rsp_data;
  end
endmodule

// File: tb/tb_sobel_rd_fetch.sv
// Directed bench for sobel_rd_fetch: ordering, credits, backpressure, boundaries, reset.
`timescale 1ns/1ps
module tb_sobel_rd_fetch;
  logic        clk, reset, start;
  logic [41:0] base_addr;
  logic [31:0] num_lines;
  logic        busy, done, err;
  int          checks, errors, n_done;

  logic [41:0]  req_addr_q[$];
  logic [3:0]   req_tag_q[$];
  logic [511:0] pop_data_q[$];
  logic         pop_last_q[$];

  sobel_rd_fetch_if #(.ADDR_W(42), .TAG_W(4)) bus ();

  sobel_rd_fetch #(.MAX_OUTSTANDING(16), .TAG_W(4), .ADDR_W(42), .SIZE_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_lines(num_lines),
    .busy(busy), .done(done), .err(err), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.rd_req_valid) begin
      req_addr_q.push_back(bus.rd_req_addr);
      req_tag_q.push_back(bus.rd_req_tag);
    end
    if (bus.blk_valid && bus.blk_ready) begin
      pop_data_q.push_back(bus.blk_data);
      pop_last_q.push_back(bus.blk_last);
    end
    if (done) n_done++;
  end

  function automatic logic [511:0] line_data(input logic [41:0] a);
    return {16{a[31:0] ^ 32'h5A5A_0000}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    req_addr_q.delete();
    req_tag_q.delete();
    pop_data_q.delete();
    pop_last_q.delete();
    n_done = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic pulse_start(input logic [41:0] b, input logic [31:0] n);
    start = 1'b1;
    base_addr = b;
    num_lines = n;
    tick();
    start = 1'b0;
  endtask

  task automatic send_rsp(input int idx);
    if (idx < req_tag_q.size()) begin
      bus.rd_rsp_valid = 1'b1;
      bus.rd_rsp_tag   = req_tag_q[idx];
      bus.rd_rsp_data  = line_data(req_addr_q[idx]);
    end
    tick();
    bus.rd_rsp_valid = 1'b0;
  endtask

  // Answers requests in issue order from index first until done is seen or budget runs out.
  task automatic drain(input int first, input int budget, output bit finished);
    int nxt = first;
    for (int c = 0; c < budget && n_done == 0; c++) begin
      if (nxt < req_tag_q.size()) begin
        bus.rd_rsp_valid = 1'b1;
        bus.rd_rsp_tag   = req_tag_q[nxt];
        bus.rd_rsp_data  = line_data(req_addr_q[nxt]);
        nxt++;
      end else begin
        bus.rd_rsp_valid = 1'b0;
      end
      tick();
    end
    bus.rd_rsp_valid = 1'b0;
    finished = (n_done > 0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b exp 0", err); end
    checks++; if (bus.rd_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got %0b exp 0", bus.rd_req_valid); end
    checks++; if (bus.rd_req_addr !== 42'h0 || bus.rd_req_tag !== 4'h0) begin
      errors++; $display("FAIL reset_req_addr_tag got %0h/%0h exp 0/0", bus.rd_req_addr, bus.rd_req_tag); end
    checks++; if (bus.blk_valid !== 1'b0) begin errors++; $display("FAIL reset_blk_valid got %0b exp 0", bus.blk_valid); end
  endtask

  task automatic test_single();
    clear_log();
    pulse_start(42'h100, 32'd1);
    checks++; if (busy !== 1'b1 || bus.rd_req_valid !== 1'b0) begin
      errors++; $display("FAIL single_t1 got busy %0b req %0b exp 1 0", busy, bus.rd_req_valid); end
    tick();
    checks++; if (bus.rd_req_valid !== 1'b1 || bus.rd_req_addr !== 42'h100 || bus.rd_req_tag !== 4'd0) begin
      errors++; $display("FAIL single_req got v%0b a%0h t%0h exp v1 a100 t0", bus.rd_req_valid, bus.rd_req_addr, bus.rd_req_tag); end
    repeat (5) tick();
    checks++; if (bus.blk_valid !== 1'b0 || req_addr_q.size() != 1) begin
      errors++; $display("FAIL single_pre_rsp got blk %0b reqs %0d exp 0 1", bus.blk_valid, req_addr_q.size()); end
    send_rsp(0);
    checks++; if (bus.blk_valid !== 1'b1 || bus.blk_last !== 1'b1 || bus.blk_data !== line_data(42'h100)) begin
      errors++; $display("FAIL single_blk got v%0b l%0b d%0h exp v1 l1", bus.blk_valid, bus.blk_last, bus.blk_data[31:0]); end
    tick();
    checks++; if (done !== 1'b1 || bus.blk_valid !== 1'b0) begin
      errors++; $display("FAIL single_done got done %0b blk %0b exp 1 0", done, bus.blk_valid); end
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL single_idle got busy %0b done %0b exp 0 0", busy, done); end
  endtask

  task automatic test_reorder();
    bit fin;
    clear_log();
    pulse_start(42'h200, 32'd4);
    repeat (5) tick();
    checks++; if (req_addr_q.size() != 4) begin errors++; $display("FAIL reorder_reqs got %0d exp 4", req_addr_q.size()); end
    send_rsp(3);
    checks++; if (bus.blk_valid !== 1'b0) begin errors++; $display("FAIL reorder_hold got %0b exp 0", bus.blk_valid); end
    send_rsp(1);
    send_rsp(0);
    send_rsp(2);
    drain(4, 20, fin);
    checks++; if (!fin || pop_data_q.size() != 4) begin
      errors++; $display("FAIL reorder_count got done %0b pops %0d exp 1 4", fin, pop_data_q.size()); end
    for (int i = 0; i < pop_data_q.size() && i < 4; i++) begin
      checks++; if (pop_data_q[i] !== line_data(42'h200 + 42'(i)) || pop_last_q[i] !== (i == 3)) begin
        errors++; $display("FAIL reorder_blk%0d got d%0h l%0b exp d%0h l%0b", i, pop_data_q[i][31:0], pop_last_q[i],
                            32'h5A5A_0200 + 32'(i), (i == 3)); end
    end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reorder_err got %0b exp 0", err); end
    tick();
  endtask

  task automatic test_credit();
    clear_log();
    pulse_start(42'h1000, 32'd40);
    repeat (40) tick();
    checks++; if (req_addr_q.size() != 16 || bus.rd_req_valid !== 1'b0) begin
      errors++; $display("FAIL credit_cap got %0d req %0b exp 16 0", req_addr_q.size(), bus.rd_req_valid); end
    for (int i = 0; i < req_addr_q.size() && i < 16; i++) begin
      checks++; if (req_tag_q[i] !== 4'(i) || req_addr_q[i] !== 42'h1000 + 42'(i)) begin
        errors++; $display("FAIL credit_req%0d got a%0h t%0h exp a%0h t%0h", i, req_addr_q[i], req_tag_q[i], 42'h1000 + 42'(i), i); end
    end
    send_rsp(0);
    repeat (6) tick();
    checks++; if (req_addr_q.size() != 17 || pop_data_q.size() != 1) begin
      errors++; $display("FAIL credit_refill got reqs %0d pops %0d exp 17 1", req_addr_q.size(), pop_data_q.size()); end
    else begin
      checks++; if (req_addr_q[16] !== 42'h1010 || req_tag_q[16] !== 4'd0) begin
        errors++; $display("FAIL credit_req16 got a%0h t%0h exp a1010 t0", req_addr_q[16], req_tag_q[16]); end
    end
    do_reset();
  endtask

  task automatic test_almfull_backpressure();
    int cnt;
    bit fin, stable;
    clear_log();
    bus.blk_ready = 1'b0;
    pulse_start(42'h3000, 32'd24);
    repeat (3) tick();
    bus.rd_req_almfull = 1'b1;
    tick();
    cnt = req_addr_q.size();
    repeat (9) tick();
    checks++; if (req_addr_q.size() != cnt || bus.rd_req_valid !== 1'b0) begin
      errors++; $display("FAIL almfull_block got %0d req %0b exp %0d 0", req_addr_q.size(), bus.rd_req_valid, cnt); end
    bus.rd_req_almfull = 1'b0;
    repeat (30) tick();
    checks++; if (req_addr_q.size() != 16) begin errors++; $display("FAIL bp_cap got %0d exp 16", req_addr_q.size()); end
    for (int i = 0; i < 4; i++) send_rsp(i);
    stable = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (bus.blk_valid !== 1'b1 || bus.blk_data !== line_data(42'h3000)) stable = 1'b0;
      tick();
    end
    checks++; if (!stable || pop_data_q.size() != 0) begin
      errors++; $display("FAIL bp_stable got stable %0b pops %0d exp 1 0", stable, pop_data_q.size()); end
    bus.blk_ready = 1'b1;
    drain(4, 400, fin);
    checks++; if (!fin || pop_data_q.size() != 24 || req_addr_q.size() != 24) begin
      errors++; $display("FAIL bp_count got done %0b pops %0d reqs %0d exp 1 24 24", fin, pop_data_q.size(), req_addr_q.size()); end
    for (int i = 0; i < pop_data_q.size() && i < 24; i++) begin
      checks++; if (pop_data_q[i] !== line_data(42'h3000 + 42'(i)) || pop_last_q[i] !== (i == 23)) begin
        errors++; $display("FAIL bp_blk%0d got d%0h l%0b exp d%0h l%0b", i, pop_data_q[i][31:0], pop_last_q[i],
                            32'h5A5A_3000 + 32'(i), (i == 23)); end
    end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL bp_err got %0b exp 0", err); end
    tick();
  endtask

  task automatic test_boundaries();
    bit fin;
    clear_log();
    pulse_start(42'h40, 32'd0);
    repeat (3) tick();
    checks++; if (n_done != 1 || req_addr_q.size() != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL zero_lines got done %0d reqs %0d busy %0b exp 1 0 0", n_done, req_addr_q.size(), busy); end
    clear_log();
    pulse_start(42'h3FF_FFFF_FFFF, 32'd2);
    drain(0, 50, fin);
    checks++; if (!fin || req_addr_q.size() != 2 || pop_data_q.size() != 2) begin
      errors++; $display("FAIL wrap_count got done %0b reqs %0d pops %0d exp 1 2 2", fin, req_addr_q.size(), pop_data_q.size()); end
    else begin
      checks++; if (req_addr_q[0] !== 42'h3FF_FFFF_FFFF || req_addr_q[1] !== 42'h0) begin
        errors++; $display("FAIL wrap_addr got %0h %0h exp 3ffffffffff 0", req_addr_q[0], req_addr_q[1]); end
      checks++; if (pop_data_q[1] !== line_data(42'h0) || pop_last_q[1] !== 1'b1) begin
        errors++; $display("FAIL wrap_data got %0h l%0b exp 5a5a0000 l1", pop_data_q[1][31:0], pop_last_q[1]); end
    end
    tick();
    tick();
    clear_log();
    pulse_start(42'h500, 32'd3);
    pulse_start(42'h900, 32'd5);
    drain(0, 60, fin);
    checks++; if (!fin || req_addr_q.size() != 3 || pop_data_q.size() != 3) begin
      errors++; $display("FAIL busy_start got done %0b reqs %0d pops %0d exp 1 3 3", fin, req_addr_q.size(), pop_data_q.size()); end
    else begin
      checks++; if (req_addr_q[2] !== 42'h502 || pop_data_q[2] !== line_data(42'h502)) begin
        errors++; $display("FAIL busy_start_addr got %0h exp 502", req_addr_q[2]); end
    end
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    bit fin;
    clear_log();
    pulse_start(42'h7000, 32'd10);
    for (int c = 0; c < 20 && req_addr_q.size() < 6; c++) tick();
    checks++; if (req_addr_q.size() < 6) begin errors++; $display("FAIL mid_reqs got %0d exp 6", req_addr_q.size()); end
    bus.rd_rsp_valid = 1'b1;
    bus.rd_rsp_tag   = 4'd12;
    bus.rd_rsp_data  = '1;
    tick();
    bus.rd_rsp_valid = 1'b0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL stray_tag_err got %0b exp 1", err); end
    reset = 1'b1;
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || bus.rd_req_valid !== 1'b0 ||
                  bus.rd_req_addr !== 42'h0 || bus.rd_req_tag !== 4'h0 || bus.blk_valid !== 1'b0) begin
      errors++; $display("FAIL mid_reset got busy %0b done %0b err %0b req %0b addr %0h tag %0h blk %0b exp all 0",
                         busy, done, err, bus.rd_req_valid, bus.rd_req_addr, bus.rd_req_tag, bus.blk_valid); end
    reset = 1'b0;
    bus.rd_rsp_valid = 1'b1;
    bus.rd_rsp_tag   = 4'd0;
    bus.rd_rsp_data  = '1;
    tick();
    bus.rd_rsp_valid = 1'b0;
    tick();
    checks++; if (bus.blk_valid !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL late_rsp got blk %0b err %0b busy %0b exp 0 0 0", bus.blk_valid, err, busy); end
    clear_log();
    pulse_start(42'h8000, 32'd3);
    drain(0, 60, fin);
    checks++; if (!fin || pop_data_q.size() != 3) begin
      errors++; $display("FAIL restart_count got done %0b pops %0d exp 1 3", fin, pop_data_q.size()); end
    for (int i = 0; i < pop_data_q.size() && i < 3; i++) begin
      checks++; if (pop_data_q[i] !== line_data(42'h8000 + 42'(i))) begin
        errors++; $display("FAIL restart_blk%0d got %0h exp %0h", i, pop_data_q[i][31:0], 32'h5A5A_8000 + 32'(i)); end
    end
    tick();
  endtask

  initial begin
    checks = 0; errors = 0; n_done = 0;
    reset = 1'b1; start = 1'b0; base_addr = '0; num_lines = '0;
    bus.rd_req_almfull = 1'b0; bus.rd_rsp_valid = 1'b0; bus.rd_rsp_tag = '0; bus.rd_rsp_data = '0;
    bus.blk_ready = 1'b1;
    test_reset();
    test_single();
    test_reorder();
    test_credit();
    test_almfull_backpressure();
    test_boundaries();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end
endmodule
